// File: rtl/column_cursor_ctrl.sv
// column_cursor_ctrl
//   Front-panel input handler for the Connect4 board. Synchronizes and
//   debounces three active-low push buttons, moves a wrapping column cursor
//   (with auto-repeat on left/right), and issues a four-phase req/ack drop
//   request carrying the cursor column and the current player.
//
// Ports:
//   clk, rst          - system clock, asynchronous active-high reset
//   btn_left_n        - raw left button, active-low, asynchronous
//   btn_right_n       - raw right button, active-low, asynchronous
//   btn_drop_n        - raw drop button, active-low, asynchronous
//   player            - current player, latched when a drop request issues
//   col               - current cursor column (0..NUM_COLS-1)
//   drop_req          - drop request, held until drop_ack is seen
//   drop_col          - column latched for the pending drop
//   drop_player       - player latched for the pending drop
//   drop_ack          - four-phase acknowledge from board logic
//   busy              - high whenever the drop handshake is not idle
module column_cursor_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000,
  parameter int unsigned REPEAT_CYCLES   = 50_000_000,
  parameter int unsigned NUM_COLS        = 7,
  parameter int unsigned COL_W           = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_left_n,
  input  logic             btn_right_n,
  input  logic             btn_drop_n,
  input  logic             player,
  output logic [COL_W-1:0] col,
  output logic             drop_req,
  output logic [COL_W-1:0] drop_col,
  output logic             drop_player,
  input  logic             drop_ack,
  output logic             busy
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RP_W = $clog2(REPEAT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RELEASE} state_t;

  // Button index: 0 = left, 1 = right, 2 = drop
  logic [2:0]      raw;
  logic [2:0]      sync1_q, sync2_q;
  logic [2:0]      db_q, db_d, db_prev_q;
  logic [DB_W-1:0] db_cnt_q [3];
  logic [DB_W-1:0] db_cnt_d [3];
  logic [RP_W-1:0] rep_cnt_q [2];
  logic [RP_W-1:0] rep_cnt_d [2];
  logic [2:0]      press;
  logic [1:0]      rep_ev;
  logic            left_ev, right_ev, drop_ev;

  state_t          state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [COL_W-1:0] drop_col_q, drop_col_d;
  logic            drop_player_q, drop_player_d;

  assign raw = {btn_drop_n, btn_right_n, btn_left_n};

  // Debounce: counter runs only while synced level disagrees with the
  // debounced level; any agreement restarts the count.
  always_comb begin
    db_d = db_q;
    for (int unsigned i = 0; i < 3; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          db_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  assign press = db_prev_q & ~db_q;

  // Repeat counter is held at zero on the press cycle and while released,
  // so the first repeat lands exactly REPEAT_CYCLES after the press event.
  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      rep_cnt_d[i] = '0;
      rep_ev[i]    = 1'b0;
      if (!db_q[i] && !press[i]) begin
        if (rep_cnt_q[i] == RP_W'(REPEAT_CYCLES - 1)) begin
          rep_ev[i] = 1'b1;
        end else begin
          rep_cnt_d[i] = rep_cnt_q[i] + RP_W'(1);
        end
      end
    end
  end

  assign left_ev  = press[0] | rep_ev[0];
  assign right_ev = press[1] | rep_ev[1];
  assign drop_ev  = press[2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      db_q      <= '1;
      db_prev_q <= '1;
      for (int unsigned i = 0; i < 3; i++) db_cnt_q[i] <= '0;
      for (int unsigned i = 0; i < 2; i++) rep_cnt_q[i] <= '0;
    end else begin
      sync1_q   <= raw;
      sync2_q   <= sync1_q;
      db_q      <= db_d;
      db_prev_q <= db_q;
      for (int unsigned i = 0; i < 3; i++) db_cnt_q[i] <= db_cnt_d[i];
      for (int unsigned i = 0; i < 2; i++) rep_cnt_q[i] <= rep_cnt_d[i];
    end
  end

  // Cursor moves only in IDLE; a same-cycle drop takes priority and
  // latches the pre-move column.
  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    drop_col_d    = drop_col_q;
    drop_player_d = drop_player_q;
    case (state_q)
      IDLE: begin
        if (drop_ev) begin
          drop_col_d    = col_q;
          drop_player_d = player;
          state_d       = REQ;
        end else if (left_ev && !right_ev) begin
          col_d = (col_q == '0) ? COL_W'(NUM_COLS - 1) : col_q - COL_W'(1);
        end else if (right_ev && !left_ev) begin
          col_d = (col_q == COL_W'(NUM_COLS - 1)) ? '0 : col_q + COL_W'(1);
        end
      end
      REQ: begin
        if (drop_ack) state_d = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        if (!drop_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      col_q         <= COL_W'(NUM_COLS / 2);
      drop_col_q    <= '0;
      drop_player_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      drop_col_q    <= drop_col_d;
      drop_player_q <= drop_player_d;
    end
  end

  assign col         = col_q;
  assign drop_col    = drop_col_q;
  assign drop_player = drop_player_q;
  assign drop_req    = (state_q == REQ);
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_column_cursor_ctrl.sv
module tb_column_cursor_ctrl;

  logic       clk;
  logic       rst;
  logic       btn_left_n, btn_right_n, btn_drop_n;
  logic       player;
  logic [2:0] col;
  logic       drop_req;
  logic [2:0] drop_col;
  logic       drop_player;
  logic       drop_ack;
  logic       busy;

  int checks;
  int failures;

  column_cursor_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_CYCLES  (16),
    .NUM_COLS       (7),
    .COL_W          (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_left_n (btn_left_n),
    .btn_right_n(btn_right_n),
    .btn_drop_n (btn_drop_n),
    .player     (player),
    .col        (col),
    .drop_req   (drop_req),
    .drop_col   (drop_col),
    .drop_player(drop_player),
    .drop_ack   (drop_ack),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // btn: 0 left, 1 right, 2 drop. Press for 'hold' cycles, then release
  // and allow the debounced release to settle.
  task automatic tap(input int btn, input int hold);
    case (btn)
      0: btn_left_n  = 1'b0;
      1: btn_right_n = 1'b0;
      default: btn_drop_n = 1'b0;
    endcase
    step(hold);
    btn_left_n  = 1'b1;
    btn_right_n = 1'b1;
    btn_drop_n  = 1'b1;
    step(10);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    btn_left_n = 1'b1;
    btn_right_n = 1'b1;
    btn_drop_n = 1'b1;
    player = 1'b0;
    drop_ack = 1'b0;
    step(2);
    chk("rst_col", 32'(col), 32'd3);
    chk("rst_req", 32'(drop_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_dcol", 32'(drop_col), 32'd0);
    chk("rst_dplayer", 32'(drop_player), 32'd0);
    rst = 1'b0;
    step(2);

    // 1: clean right press, move lands on the 7th edge after the raw edge
    btn_right_n = 1'b0;
    step(6);
    chk("t1_before", 32'(col), 32'd3);
    step(1);
    chk("t1_move", 32'(col), 32'd4);
    step(2);
    btn_right_n = 1'b1;
    step(10);
    chk("t1_once", 32'(col), 32'd4);
    chk("t1_noreq", 32'(drop_req), 32'd0);

    // 2: left presses from 4 -> 3,2,1,0,6,5 (wrap at 0), then a glitch
    tap(0, 8); chk("t2_l0", 32'(col), 32'd3);
    tap(0, 8); chk("t2_l1", 32'(col), 32'd2);
    tap(0, 8); chk("t2_l2", 32'(col), 32'd1);
    tap(0, 8); chk("t2_l3", 32'(col), 32'd0);
    tap(0, 8); chk("t2_wrap", 32'(col), 32'd6);
    tap(0, 8); chk("t2_l5", 32'(col), 32'd5);
    tap(0, 2); chk("t2_glitch", 32'(col), 32'd5);

    // 3: hold right from 5: 6 at press, 0 at +16, 1 at +32
    btn_right_n = 1'b0;
    step(7);
    chk("t3_press", 32'(col), 32'd6);
    step(15);
    chk("t3_pre_rep1", 32'(col), 32'd6);
    step(1);
    chk("t3_rep1_wrap", 32'(col), 32'd0);
    step(15);
    chk("t3_pre_rep2", 32'(col), 32'd0);
    step(1);
    chk("t3_rep2", 32'(col), 32'd1);
    step(6);
    btn_right_n = 1'b1;   // debounced release lands before the next repeat
    step(20);
    chk("t3_after_release", 32'(col), 32'd1);

    // 4: move to 4, drop with player=1, delayed ack
    tap(1, 8); tap(1, 8); tap(1, 8);
    chk("t4_col", 32'(col), 32'd4);
    player = 1'b1;
    btn_drop_n = 1'b0;
    step(6);
    chk("t4_req_pre", 32'(drop_req), 32'd0);
    step(1);
    chk("t4_req", 32'(drop_req), 32'd1);
    chk("t4_dcol", 32'(drop_col), 32'd4);
    chk("t4_dplayer", 32'(drop_player), 32'd1);
    chk("t4_busy", 32'(busy), 32'd1);
    btn_drop_n = 1'b1;
    player = 1'b0;
    step(5);
    chk("t4_req_hold", 32'(drop_req), 32'd1);
    chk("t4_dcol_hold", 32'(drop_col), 32'd4);
    chk("t4_dplayer_hold", 32'(drop_player), 32'd1);
    drop_ack = 1'b1;
    step(1);
    chk("t4_req_drop", 32'(drop_req), 32'd0);
    chk("t4_busy_wait", 32'(busy), 32'd1);
    step(2);
    chk("t4_busy_ackhi", 32'(busy), 32'd1);
    drop_ack = 1'b0;
    step(1);
    chk("t4_idle", 32'(busy), 32'd0);
    step(10);

    // 5: events during REQ are ignored; new request after handshake
    tap(2, 7);
    chk("t5_req", 32'(drop_req), 32'd1);
    tap(0, 8);
    chk("t5_col_frozen", 32'(col), 32'd4);
    tap(2, 8);
    chk("t5_req_still", 32'(drop_req), 32'd1);
    drop_ack = 1'b1;
    step(1);
    chk("t5_req_low", 32'(drop_req), 32'd0);
    drop_ack = 1'b0;
    step(1);
    chk("t5_idle", 32'(busy), 32'd0);
    step(10);
    chk("t5_no_second", 32'(drop_req), 32'd0);
    btn_drop_n = 1'b0;
    step(7);
    chk("t5_new_req", 32'(drop_req), 32'd1);
    chk("t5_new_dplayer", 32'(drop_player), 32'd0);
    btn_drop_n = 1'b1;
    drop_ack = 1'b1;
    step(1);
    drop_ack = 1'b0;
    step(10);
    chk("t5_done", 32'(busy), 32'd0);

    // 6: async reset during REQ with col=6
    tap(1, 8); tap(1, 8);
    chk("t6_col", 32'(col), 32'd6);
    btn_drop_n = 1'b0;
    step(7);
    chk("t6_req", 32'(drop_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_req", 32'(drop_req), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_col", 32'(col), 32'd3);
    btn_drop_n = 1'b1;
    step(2);
    rst = 1'b0;
    drop_ack = 1'b1;
    step(10);
    chk("t6_ack_ign_req", 32'(drop_req), 32'd0);
    chk("t6_ack_ign_busy", 32'(busy), 32'd0);
    chk("t6_ack_ign_col", 32'(col), 32'd3);
    drop_ack = 1'b0;
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
